// File: rtl/program_sequencer_pkg.sv
// Shared defaults and the next-PC select encoding for the program sequencer.
package program_sequencer_pkg;

  localparam int PC_W_DEF     = 11;
  localparam int DEPTH_DEF    = 8;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_BSR,
    SEL_JMP,
    SEL_INC
  } next_sel_e;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// DEPTH x W return-address LIFO; full/empty guards make illegal push/pop no-ops.
module return_stack
  import program_sequencer_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_top;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !push && !empty;

  // Top entry sits one below the count; dout is meaningless while empty.
  assign w_top = r_count - CW'(1);
  assign dout  = r_mem[w_top[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Contents need no reset: an empty stack is never read.
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      r_mem[r_count[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with subroutine return stack; picks the next address by priority each clock.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  localparam int             SP_W     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            pre_load,
  input  logic            is_bsr,
  input  logic            is_ret,
  input  logic [PC_W-1:0] s,
  output logic [PC_W-1:0] pc,
  output logic [SP_W-1:0] sp,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            ovf,
  output logic            udf
);

  logic [PC_W-1:0] r_pc;
  logic            r_ovf;
  logic            r_udf;
  next_sel_e       w_sel;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_top;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  always_comb begin
    w_sel = SEL_INC;
    if (hold) begin
      w_sel = SEL_HOLD;
    end else if (is_ret) begin
      w_sel = SEL_RET;
    end else if (is_bsr) begin
      w_sel = SEL_BSR;
    end else if (pre_load) begin
      w_sel = SEL_JMP;
    end
  end

  // Wraps modulo 2^PC_W; the pushed return address wraps the same way.
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_push   = (w_sel == SEL_BSR);
  assign w_pop    = (w_sel == SEL_RET);

  return_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_top),
    .count (sp),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      case (w_sel)
        SEL_HOLD: r_pc <= r_pc;
        SEL_RET: begin
          if (w_empty) begin
            r_pc  <= w_pc_inc;
            r_udf <= 1'b1;
          end else begin
            r_pc <= w_top;
          end
        end
        SEL_BSR: begin
          r_pc <= s;
          if (w_full) begin
            r_ovf <= 1'b1;
          end
        end
        SEL_JMP: r_pc <= s;
        default: r_pc <= w_pc_inc;
      endcase
    end
  end

  assign pc          = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf         = r_ovf;
  assign udf         = r_udf;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed table, hand sequences, and random stimulus vs. a queue model.
module tb_program_sequencer;

  localparam int PC_W  = 11;
  localparam int DEPTH = 8;
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << PC_W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            hold = 1'b0;
  logic            pre_load = 1'b0;
  logic            is_bsr = 1'b0;
  logic            is_ret = 1'b0;
  logic [PC_W-1:0] s = '0;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            stack_full;
  logic            stack_empty;
  logic            ovf;
  logic            udf;

  int total = 0;
  int bad   = 0;

  // Reference model: return addresses as a queue, back is top of stack.
  int m_pc  = 0;
  int m_q[$];
  int m_ovf = 0;
  int m_udf = 0;

  typedef struct {
    logic            rst;
    logic            hld;
    logic            pl;
    logic            bsr;
    logic            ret;
    logic [PC_W-1:0] tgt;
    int              e_pc;
    int              e_sp;
  } vec_t;

  vec_t tbl[$];

  program_sequencer #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .pre_load    (pre_load),
    .is_bsr      (is_bsr),
    .is_ret      (is_ret),
    .s           (s),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic h, input logic p, input logic b,
                            input logic t, input int tgt);
    if (r) begin
      m_pc = 0;
      m_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else if (h) begin
      // frozen
    end else if (t) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc  = (m_pc + 1) & MASK;
        m_udf = 1;
      end
    end else if (b) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) & MASK);
      else m_ovf = 1;
      m_pc = tgt;
    end else if (p) begin
      m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic p, input logic b,
                      input logic t, input int tgt);
    reset    = r;
    hold     = h;
    pre_load = p;
    is_bsr   = b;
    is_ret   = t;
    s        = PC_W'(tgt);
    @(posedge clk);
    model_edge(r, h, p, b, t, tgt);
    #1;
    chk("pc", int'(pc), m_pc);
    chk("sp", int'(sp), m_q.size());
    chk("full", int'(stack_full), int'(m_q.size() == DEPTH));
    chk("empty", int'(stack_empty), int'(m_q.size() == 0));
    chk("ovf", int'(ovf), m_ovf);
    chk("udf", int'(udf), m_udf);
  endtask

  function automatic vec_t mk(input logic r, input logic h, input logic p, input logic b,
                              input logic t, input int tgt, input int epc, input int esp);
    vec_t v;
    v.rst = r; v.hld = h; v.pl = p; v.bsr = b; v.ret = t;
    v.tgt = PC_W'(tgt); v.e_pc = epc; v.e_sp = esp;
    return v;
  endfunction

  initial begin
    // Directed table: reset, idle, jump/hold, nested calls, wrap-around.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 'h000, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, i, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h010, 'h010, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h123, 'h010, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 'h555, 'h010, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h123, 'h123, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h020, 'h020, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h100, 'h100, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h101, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h102, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h200, 'h200, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h103, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h021, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h7FF, 'h7FF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h000, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h7FF, 'h7FF, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h050, 'h050, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h000, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h0AA, 'h0AA, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 'h0BB, 'h001, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].hld, tbl[i].pl, tbl[i].bsr, tbl[i].ret, int'(tbl[i].tgt));
      chk($sformatf("tbl%0d_pc", i), int'(pc), tbl[i].e_pc);
      chk($sformatf("tbl%0d_sp", i), int'(sp), tbl[i].e_sp);
    end

    // Overflow then underflow.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 'h300);
    for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 1, 0, 'h400 + i);
    chk("ovf_pc", int'(pc), 'h408);
    chk("ovf_sp", int'(sp), DEPTH);
    chk("ovf_flag", int'(ovf), 1);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk($sformatf("lifo%0d", k), int'(pc), (k < DEPTH - 1) ? ('h407 - k) : 'h301);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("udf_pc", int'(pc), 'h302);
    chk("udf_flag", int'(udf), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 'h010 * i);
    chk("sticky_ovf", int'(ovf), 1);
    chk("sticky_udf", int'(udf), 1);

    // Reset while returning with three entries on the stack.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 'h600 + i);
    chk("pre_rst_sp", int'(sp), 3);
    step(1, 0, 0, 0, 1, 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_udf", int'(udf), 0);
    chk("rst_empty", int'(stack_empty), 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic r, h, p, b, t;
      r = ($urandom_range(0, 199) == 0);
      h = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 3) == 0);
      step(r, h, p, b, t, int'($urandom_range(0, MASK)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Owns the program counter and the subroutine return stack for the Unión Mágica core.
- Consumes the jump-decode outputs (pre_load, is_BSR, is_RET, S) and produces the next instruction address every clock.
- Sits between the jump-decode block and the instruction memory address port.

Parameters:
- PC_W, 11, program counter width; matches the width of the jump target S.
- DEPTH, 8, number of return-address entries in the LIFO; must be at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  stall; freezes PC and stack while high.
- pre_load  in  1  take jump (jmp/jze/jne/ccy condition already resolved upstream).
- is_bsr  in  1  subroutine call.
- is_ret  in  1  subroutine return.
- s  in  PC_W  jump or call target.
- pc  out  PC_W  current instruction address (registered).
- sp  out  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  out  1  sp == DEPTH.
- stack_empty  out  1  sp == 0.
- ovf  out  1  sticky: a call was made with the stack full.
- udf  out  1  sticky: a return was made with the stack empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Values on reset:
  - pc = RESET_PC, sp = 0.
  - stack_empty = 1, stack_full = 0, ovf = 0, udf = 0.
  - Stack contents are don't-care.
- Reset mid-call or mid-return discards the whole stack.
- Update rule: one update per cycle when hold = 0. The next PC is selected by strict priority:
  1. reset
  2. hold: pc, sp, stack and flags unchanged; control inputs ignored; no flag is set.
  3. is_ret:
     - Stack not empty: pc <= top entry, sp <= sp-1.
     - Stack empty: pc <= pc+1, udf <= 1.
  4. is_bsr: pc <= s, and the return address pc+1 is pushed.
     - Stack not full: push, sp <= sp+1.
     - Stack full: push discarded, sp unchanged, ovf <= 1, jump still taken.
  5. pre_load: pc <= s; stack untouched.
  6. Otherwise: pc <= pc+1.
- Latency: inputs sampled at edge N give the new pc valid after edge N; no combinational path from inputs to pc.
- Arithmetic: pc+1 is modulo 2^PC_W, so 0x7FF+1 = 0x000. A pushed return address wraps the same way.
- Simultaneous controls: upstream decode makes is_bsr, is_ret and pre_load mutually exclusive. If more than one is asserted anyway, the priority above applies and no error is flagged.
- Error flags: ovf and udf are cleared only by reset.
- Stack: true LIFO; the top entry is always the most recent push.
  - A RET immediately after a BSR returns that BSR's pc+1.
  - Push and pop never occur in the same cycle.

Decomposition:
- Shared package (program_sequencer_pkg):
  - PC_W and DEPTH defaults.
  - RESET_PC.
  - Next-PC select enum: SEL_HOLD, SEL_RET, SEL_BSR, SEL_JMP, SEL_INC.
- Sub-module return_stack (DEPTH x PC_W LIFO):
  - Inputs: push, pop, din.
  - Outputs: dout (top), count, full, empty.
  - Full/empty guards live inside the sub-module.
  - Sticky flags and PC selection stay in program_sequencer.

Test Plan:
- Reset then 5 idle cycles -> pc = 0,1,2,3,4,5; sp = 0; stack_empty = 1.
- pc=0x010, pre_load=1, s=0x123 -> next pc = 0x123, sp unchanged. Same stimulus with hold=1 -> pc stays 0x010.
- Nested calls:
  - pc=0x020, is_bsr s=0x100 -> pc = 0x100, sp = 1.
  - After 2 increments, is_bsr s=0x200 -> pc = 0x200, sp = 2.
  - is_ret -> pc = 0x103, sp = 1.
  - is_ret -> pc = 0x021, sp = 0.
- Overflow and underflow:
  - DEPTH+1 consecutive BSRs -> the last one jumps, sp = DEPTH, ovf = 1.
  - DEPTH RETs return the first DEPTH addresses in LIFO order.
  - One more RET -> pc increments, udf = 1.
  - ovf and udf stay high until reset.
- Wrap-around:
  - pc=0x7FF idle -> pc = 0x000.
  - BSR at pc=0x7FF with s=0x050, then RET -> pc = 0x000.
- Reset asserted with sp=3 while is_ret=1 -> pc = RESET_PC, sp = 0, flags 0, RET ignored.
